// File: rtl/mem_stage_if.sv
// mem_stage_if -- bundle of the execute->memory handshake, data-memory bus
// and writeback signals of the memory pipeline stage.
//   ex_*   : instruction from execute (valid/ready handshake)
//   dmem_* : single outstanding request to data memory, held until ack
//   wb_*   : writeback result, wb_valid/mem_err are one-cycle pulses
// modport slave  : the memory stage itself
// modport master : its environment (execute stage, memory, writeback)
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        mem_err;

    modport slave (
        input  ex_valid, ex_alu_out, ex_store_data, ex_mem_read, ex_mem_write,
               ex_funct3, ex_rd, ex_reg_write, dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_rd, wb_reg_write, wb_data, mem_err
    );

    modport master (
        output ex_valid, ex_alu_out, ex_store_data, ex_mem_read, ex_mem_write,
               ex_funct3, ex_rd, ex_reg_write, dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_rd, wb_reg_write, wb_data, mem_err
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- memory pipeline stage of a 32-bit RISC-V style core.
// Non-memory ops pass straight to writeback with one cycle of latency.
// Loads/stores issue one word-aligned data-memory request, held stable until
// dmem_ack or until TIMEOUT cycles elapse; misaligned or illegal accesses are
// rejected without touching memory and flagged on mem_err.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_stage_if.slave (ex_* in, dmem_* out/ack in, wb_* / mem_err out)
// Parameter:
//   TIMEOUT : max cycles dmem_req is held waiting for dmem_ack (>= 1)
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value in the last REQ cycle allowed before giving up.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    // Facts about the in-flight access needed when the response arrives.
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } acc_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    acc_t          acc_q, acc_d;

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_rw_q, wb_rw_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          err_q, err_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        is_mem, f3_bad, misal, acc_err;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    assign is_mem = bus.ex_mem_read | bus.ex_mem_write;

    // Stores have no unsigned variants, so any funct3[2] on a store is bad.
    assign f3_bad = (bus.ex_funct3 == 3'b011) | (bus.ex_funct3 == 3'b110) |
                    (bus.ex_funct3 == 3'b111) |
                    (bus.ex_mem_write & bus.ex_funct3[2]);

    assign misal = ((bus.ex_funct3[1:0] == 2'b01) & bus.ex_alu_out[0]) |
                   ((bus.ex_funct3[1:0] == 2'b10) & (bus.ex_alu_out[1:0] != 2'b00));

    assign acc_err = is_mem & ((bus.ex_mem_read & bus.ex_mem_write) | f3_bad | misal);

    // Store data is replicated across the word so the byte enables alone
    // pick the target lanes; loads always fetch the whole word.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = bus.ex_store_data;
        if (bus.ex_mem_write) begin
            case (bus.ex_funct3[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << bus.ex_alu_out[1:0];
                    lane_wdata = {4{bus.ex_store_data[7:0]}};
                end
                2'b01: begin
                    lane_be    = bus.ex_alu_out[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{bus.ex_store_data[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = bus.ex_store_data;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign ld_byte = bus.dmem_rdata[{acc_q.addr_lo, 3'b000} +: 8];
    assign ld_half = acc_q.addr_lo[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

    always_comb begin
        case (acc_q.funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            IDLE: begin
                // dmem_ack is deliberately not looked at here.
                if (bus.ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.ex_rd;
                        wb_rw_d    = bus.ex_reg_write;
                        wb_data_d  = bus.ex_alu_out;
                    end else if (acc_err) begin
                        wb_valid_d = 1'b1;
                        err_d      = 1'b1;
                        wb_rd_d    = bus.ex_rd;
                        wb_rw_d    = 1'b0;
                    end else begin
                        state_d       = REQ;
                        cnt_d         = '0;
                        req_d         = 1'b1;
                        we_d          = bus.ex_mem_write;
                        addr_d        = {bus.ex_alu_out[31:2], 2'b00};
                        be_d          = lane_be;
                        wdata_d       = lane_wdata;
                        acc_d.addr_lo = bus.ex_alu_out[1:0];
                        acc_d.funct3  = bus.ex_funct3;
                        acc_d.rd      = bus.ex_rd;
                        acc_d.reg_write = bus.ex_reg_write;
                        acc_d.is_load = bus.ex_mem_read;
                    end
                end
            end
            REQ: begin
                // Ack wins over timeout when both land in the same cycle.
                if (bus.dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = acc_q.rd;
                    wb_rw_d    = acc_q.is_load & acc_q.reg_write;
                    if (acc_q.is_load)
                        wb_data_d = ld_data;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
                    wb_rd_d    = acc_q.rd;
                    wb_rw_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.ex_ready     = (state_q == IDLE);
    assign bus.dmem_req     = req_q;
    assign bus.dmem_we      = we_q;
    assign bus.dmem_addr    = addr_q;
    assign bus.dmem_be      = be_q;
    assign bus.dmem_wdata   = wdata_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_reg_write = wb_rw_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    logic clk;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_out    = '0;
        bus.ex_store_data = '0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_funct3     = '0;
        bus.ex_rd         = '0;
        bus.ex_reg_write  = 1'b0;
        bus.dmem_ack      = 1'b0;
        bus.dmem_rdata    = '0;
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic rw);
        bus.ex_valid      = 1'b1;
        bus.ex_mem_read   = rd_en;
        bus.ex_mem_write  = wr_en;
        bus.ex_funct3     = f3;
        bus.ex_alu_out    = a;
        bus.ex_store_data = sd;
        bus.ex_rd         = r;
        bus.ex_reg_write  = rw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr();
        #12;
        total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_be} !== 6'b0) $display("FAIL reset_dmem: got req/we/be %b expected 0", {bus.dmem_req, bus.dmem_we, bus.dmem_be}); else passed++;
        total++; if ({bus.dmem_addr, bus.dmem_wdata} !== 64'h0) $display("FAIL reset_addr: got %h expected 0", {bus.dmem_addr, bus.dmem_wdata}); else passed++;
        total++; if ({bus.wb_valid, bus.wb_reg_write, bus.mem_err, bus.wb_rd, bus.wb_data} !== 40'h0) $display("FAIL reset_wb: got %h expected 0", {bus.wb_valid, bus.wb_reg_write, bus.mem_err, bus.wb_rd, bus.wb_data}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (bus.ex_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ex_ready); else passed++;
    endtask

    task automatic test_nonmem();
        drive(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd5, 1'b1);
        step();
        total++; if ({bus.wb_valid, bus.wb_rd, bus.wb_reg_write, bus.wb_data} !== {1'b1, 5'd5, 1'b1, 32'h42}) $display("FAIL nonmem_wb: got v=%b rd=%0d rw=%b d=%h expected v=1 rd=5 rw=1 d=42", bus.wb_valid, bus.wb_rd, bus.wb_reg_write, bus.wb_data); else passed++;
        total++; if ({bus.dmem_req, bus.mem_err, bus.ex_ready} !== 3'b001) $display("FAIL nonmem_side: got req/err/rdy %b expected 001", {bus.dmem_req, bus.mem_err, bus.ex_ready}); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 3'b000, 32'h100 + 32'(i), 32'h0, 5'(10 + i), 1'b1);
            step();
            total++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'(10 + i), 32'h100 + 32'(i)}) $display("FAIL b2b_%0d: got v=%b rd=%0d d=%h expected v=1 rd=%0d d=%h", i, bus.wb_valid, bus.wb_rd, bus.wb_data, 10 + i, 32'h100 + 32'(i)); else passed++;
        end
        clr();
        step();
        total++; if ({bus.wb_valid, bus.wb_data} !== {1'b0, 32'h103}) $display("FAIL b2b_pulse_hold: got v=%b d=%h expected v=0 d=103", bus.wb_valid, bus.wb_data); else passed++;
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] exp, input string nm);
        drive(1'b1, 1'b0, f3, 32'h0000_1003, 32'h0, 5'd9, 1'b1);
        step();
        clr();
        total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.ex_ready} !== {1'b1, 1'b0, 4'hF, 32'h1000, 1'b0}) $display("FAIL %s_req: got req=%b we=%b be=%b addr=%h rdy=%b expected 1 0 1111 00001000 0", nm, bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.ex_ready); else passed++;
        step();
        total++; if ({bus.dmem_req, bus.ex_ready, bus.wb_valid} !== 3'b100) $display("FAIL %s_wait: got req/rdy/wbv %b expected 100", nm, {bus.dmem_req, bus.ex_ready, bus.wb_valid}); else passed++;
        step();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h80FF_FFFF;
        step();
        clr();
        total++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_reg_write} !== {1'b1, exp, 5'd9, 1'b1}) $display("FAIL %s_data: got v=%b d=%h rd=%0d rw=%b expected v=1 d=%h rd=9 rw=1", nm, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_reg_write, exp); else passed++;
        total++; if ({bus.dmem_req, bus.mem_err, bus.ex_ready} !== 3'b001) $display("FAIL %s_done: got req/err/rdy %b expected 001", nm, {bus.dmem_req, bus.mem_err, bus.ex_ready}); else passed++;
        step();
    endtask

    task automatic test_store();
        drive(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd7, 1'b1);
        step();
        clr();
        total++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD_ABCD}) $display("FAIL sh_req: got req=%b we=%b be=%b addr=%h wd=%h expected 1 1 1100 00002000 abcdabcd", bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata); else passed++;
        bus.dmem_ack = 1'b1;
        step();
        clr();
        total++; if ({bus.wb_valid, bus.wb_reg_write, bus.mem_err, bus.dmem_req} !== 4'b1000) $display("FAIL sh_wb: got v/rw/err/req %b expected 1000", {bus.wb_valid, bus.wb_reg_write, bus.mem_err, bus.dmem_req}); else passed++;
        drive(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h5566_77EF, 5'd7, 1'b0);
        step();
        clr();
        total++; if ({bus.dmem_be, bus.dmem_wdata, bus.dmem_addr} !== {4'b0010, 32'hEFEF_EFEF, 32'h2000}) $display("FAIL sb_req: got be=%b wd=%h addr=%h expected 0010 efefefef 00002000", bus.dmem_be, bus.dmem_wdata, bus.dmem_addr); else passed++;
        bus.dmem_ack = 1'b1;
        step();
        clr();
        step();
    endtask

    task automatic test_errors();
        logic [2:0]  f3s   [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        logic [31:0] addrs [5] = '{32'h3001, 32'h3001, 32'h3000, 32'h3000, 32'h3000};
        logic        wrs   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        rds   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(rds[i], wrs[i], f3s[i], addrs[i], 32'h0, 5'd4, 1'b1);
            step();
            clr();
            total++; if ({bus.dmem_req, bus.mem_err, bus.wb_valid, bus.wb_reg_write, bus.ex_ready} !== 5'b01101) $display("FAIL err_%0d: got req/err/v/rw/rdy %b expected 01101", i, {bus.dmem_req, bus.mem_err, bus.wb_valid, bus.wb_reg_write, bus.ex_ready}); else passed++;
            step();
            total++; if ({bus.mem_err, bus.wb_valid, bus.dmem_req} !== 3'b000) $display("FAIL err_pulse_%0d: got err/v/req %b expected 000", i, {bus.mem_err, bus.wb_valid, bus.dmem_req}); else passed++;
        end
        // LH at an even halfword address is legal and selects the upper half.
        drive(1'b1, 1'b0, 3'b001, 32'h3002, 32'h0, 5'd6, 1'b1);
        step();
        clr();
        total++; if ({bus.dmem_req, bus.dmem_addr} !== {1'b1, 32'h3000}) $display("FAIL lh_ok_req: got req=%b addr=%h expected 1 00003000", bus.dmem_req, bus.dmem_addr); else passed++;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h8001_1234;
        step();
        clr();
        total++; if ({bus.wb_valid, bus.mem_err, bus.wb_data} !== {1'b1, 1'b0, 32'hFFFF_8001}) $display("FAIL lh_ok_data: got v=%b err=%b d=%h expected 1 0 ffff8001", bus.wb_valid, bus.mem_err, bus.wb_data); else passed++;
        step();
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd8, 1'b1);
        step();
        clr();
        for (int k = 1; k <= 4; k++) begin
            total++; if ({bus.dmem_req, bus.mem_err, bus.wb_valid} !== 3'b100) $display("FAIL to_wait_%0d: got req/err/v %b expected 100", k, {bus.dmem_req, bus.mem_err, bus.wb_valid}); else passed++;
            step();
        end
        total++; if ({bus.dmem_req, bus.mem_err, bus.wb_valid, bus.wb_reg_write, bus.ex_ready} !== 5'b01101) $display("FAIL to_fire: got req/err/v/rw/rdy %b expected 01101", {bus.dmem_req, bus.mem_err, bus.wb_valid, bus.wb_reg_write, bus.ex_ready}); else passed++;
        step();
        total++; if ({bus.mem_err, bus.wb_valid} !== 2'b00) $display("FAIL to_pulse: got err/v %b expected 00", {bus.mem_err, bus.wb_valid}); else passed++;
        // Ack arriving in the final allowed cycle counts as success.
        drive(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd8, 1'b1);
        step();
        clr();
        step();
        step();
        step();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h1122_3344;
        step();
        clr();
        total++; if ({bus.wb_valid, bus.mem_err, bus.wb_reg_write, bus.wb_data} !== {1'b1, 1'b0, 1'b1, 32'h1122_3344}) $display("FAIL to_ack_last: got v=%b err=%b rw=%b d=%h expected 1 0 1 11223344", bus.wb_valid, bus.mem_err, bus.wb_reg_write, bus.wb_data); else passed++;
        step();
    endtask

    task automatic test_idle_ack();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        step();
        clr();
        total++; if ({bus.wb_valid, bus.mem_err, bus.dmem_req, bus.ex_ready} !== 4'b0001) $display("FAIL idle_ack: got v/err/req/rdy %b expected 0001", {bus.wb_valid, bus.mem_err, bus.dmem_req, bus.ex_ready}); else passed++;
    endtask

    task automatic test_reset_mid_req();
        drive(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd2, 1'b1);
        step();
        clr();
        total++; if (bus.dmem_req !== 1'b1) $display("FAIL rst_mid_pre: got req=%b expected 1", bus.dmem_req); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.dmem_req !== 1'b0) $display("FAIL rst_mid_async: got req=%b expected 0", bus.dmem_req); else passed++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if ({bus.wb_valid, bus.mem_err, bus.dmem_req, bus.ex_ready} !== 4'b0001) $display("FAIL rst_mid_after_%0d: got v/err/req/rdy %b expected 0001", k, {bus.wb_valid, bus.mem_err, bus.dmem_req, bus.ex_ready}); else passed++;
        end
        drive(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd3, 1'b1);
        step();
        clr();
        total++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd3, 32'h77}) $display("FAIL rst_mid_next: got v=%b rd=%0d d=%h expected 1 3 00000077", bus.wb_valid, bus.wb_rd, bus.wb_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_back_to_back();
        test_load(3'b000, 32'hFFFF_FF80, "lb");
        test_load(3'b100, 32'h0000_0080, "lbu");
        test_store();
        test_errors();
        test_timeout();
        test_idle_ack();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles dmem_req is held waiting for dmem_ack.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; ports clk, rst_n are listed first below.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ex_valid  input  1  execute stage presents an instruction.
REQ-006 ex_ready  output  1  block accepts; transfer occurs when ex_valid & ex_ready at a rising edge.
REQ-007 ex_alu_out  input  32  ALU result; byte address for memory ops.
REQ-008 ex_store_data  input  32  rs2 value for stores.
REQ-009 ex_mem_read / ex_mem_write  input  1 each  load / store instruction.
REQ-010 ex_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 ex_rd  input  5; ex_reg_write  input  1  destination register and its write enable.
REQ-012 dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32 (bits[1:0]=00); dmem_be  output  4; dmem_wdata  output  32.
REQ-013 dmem_ack  input  1; dmem_rdata  input  32  word valid in the cycle dmem_ack=1.
REQ-014 wb_valid  output  1; wb_rd  output  5; wb_reg_write  output  1; wb_data  output  32  writeback result.
REQ-015 mem_err  output  1  one-cycle pulse: misaligned, illegal funct3, read&write both set, or timeout.

Function
REQ-016 FSM states SHALL be IDLE, REQ; ex_ready SHALL equal (state==IDLE).
REQ-017 Non-memory op accepted in IDLE: next cycle wb_valid=1, wb_data=ex_alu_out, wb_rd/wb_reg_write as presented; latency 1; state stays IDLE.
REQ-018 Legal memory op accepted in IDLE: next cycle state=REQ, dmem_req=1; dmem_addr={addr[31:2],2'b00}; dmem_we=ex_mem_write; all dmem_* held stable until ack.
REQ-019 Store lanes: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011 (addr[1]=0) or 1100, wdata=halfword replicated x2; SW be=1111, wdata=store data. Loads: be=1111.
REQ-020 In REQ with dmem_ack=1: dmem_req drops next cycle, state returns to IDLE, wb_valid pulses that same next cycle (ack-to-wb latency 1).
REQ-021 Load result: byte/halfword selected by addr[1:0]/addr[1]; B,H sign-extend; BU,HU zero-extend; W passes through. Store: wb_reg_write=0.
REQ-022 Misaligned (H/HU addr[0]=1; W addr[1:0]!=0), illegal funct3 (011,110,111; or 1xx on store), or ex_mem_read&ex_mem_write: no dmem_req; next cycle mem_err=1, wb_valid=1, wb_reg_write=0.
REQ-023 Wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack; when it reaches TIMEOUT, req drops, mem_err and wb_valid (wb_reg_write=0) pulse, state returns IDLE.
REQ-024 dmem_ack in the same cycle the counter reaches TIMEOUT SHALL be treated as success, not timeout.
REQ-025 dmem_ack while state==IDLE SHALL be ignored.
REQ-026 wb_valid and mem_err SHALL be single-cycle pulses; wb_* fields hold last value when wb_valid=0.
REQ-027 A new instruction SHALL be accepted in the same cycle wb_valid pulses (back-to-back throughput 1 for non-memory ops).

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, mem_err=0; ex_ready=1 after release.
REQ-029 Reset asserted while in REQ SHALL abandon the access; no wb_valid or mem_err follows release.

Verification
REQ-030 Non-mem op, alu_out=0x0000_0042, rd=5 -> next cycle wb_valid=1, wb_data=0x42, wb_rd=5; 4 back-to-back ops -> 4 consecutive wb pulses.
REQ-031 LB addr=0x1003, ack after 3 cycles with rdata=0x80FF_FFFF -> dmem_addr=0x1000, ex_ready=0 while waiting, wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-032 SH addr=0x2002, store_data=0x1234_ABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_reg_write=0.
REQ-033 LW addr=0x3001 -> no dmem_req, mem_err=1 and wb_valid=1 next cycle; LH addr=0x3001 same; LH addr=0x3002 succeeds.
REQ-034 TIMEOUT=4, no ack -> dmem_req high exactly 4 cycles then mem_err pulse; ack on the 4th cycle -> normal wb, no mem_err.
REQ-035 rst_n low 2 cycles mid-REQ -> dmem_req falls asynchronously, no wb_valid after release, next op accepted normally.
